pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter generation and fetch-control stage that drives the `PC` input of the instruction memory. It holds the architectural PC and selects the next PC: sequential, taken branch, or JALR target. It checks every target for alignment and memory range. A small run/halt/trap state machine gates fetch, and a retired-instruction counter is maintained.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC / address width.
- `RESET_VEC`, 32'h0000_0000: PC loaded on reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a fetch trap.
- `MEM_SIZE`, 512: instruction memory depth in 32-bit words; fetch range check limit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and all state for this cycle (RUN only).
- `pc_src`  in  2  next-PC select:
  - 00: PC+4
  - 01: PC+imm (taken branch / JAL)
  - 10: (rs1_data+imm) & ~1 (JALR)
  - 11: treated as 00
- `imm`  in  32  sign-extended immediate from decode.
- `rs1_data`  in  32  register-file rs1 read data.
- `halt_req`  in  1  request halt after the current instruction.
- `resume`  in  1  leave HALT or TRAP.
- `PC`  out  ADDR_WIDTH  current fetch address, to instruction memory.
- `pc_plus4`  out  ADDR_WIDTH  PC+4, combinational; link value for JAL/JALR.
- `fetch_valid`  out  1  high when the current `PC`/instruction is executing.
- `trap`  out  1  high while in TRAP.
- `trap_cause`  out  2  01 misaligned target, 10 out-of-range target, 00 none.
- `trap_pc`  out  ADDR_WIDTH  PC of the instruction whose target trapped.
- `instret`  out  32  retired-instruction count.

## Operation
- States: BOOT, RUN, HALT, TRAP.
- Reset (asynchronous): state=BOOT, `PC`=RESET_VEC, `fetch_valid`=0, `trap`=0, `trap_cause`=00, `trap_pc`=0, `instret`=0. Reset mid-operation aborts any state immediately.
- BOOT: `fetch_valid`=0; unconditionally moves to RUN on the next edge; PC unchanged.
- RUN: `fetch_valid`=1.
  - With `stall`=1: nothing changes.
  - With `stall`=0, compute target per `pc_src`, then apply in priority order:
    - target[1:0]≠00 → TRAP: `trap_cause`=01, `trap_pc`=PC, `PC`=TRAP_VEC, `instret` unchanged.
    - Else target[ADDR_WIDTH-1:2] ≥ MEM_SIZE → TRAP: `trap_cause`=10, same updates.
    - Else `PC`=target and `instret`+1; if `halt_req`=1 also go to HALT.
  - Trap takes priority over halt_req.
- HALT: `fetch_valid`=0, PC held, `stall` and `halt_req` ignored. `resume`=1 → RUN next edge.
- TRAP: `trap`=1, `fetch_valid`=0, PC held at TRAP_VEC. `resume`=1 → RUN; `trap` clears. `trap_cause`/`trap_pc` are retained until the next trap or reset.
- `resume` in RUN or BOOT is ignored.
- Arithmetic: all additions are modulo 2^ADDR_WIDTH. JALR clears bit 0 only, so a bit-1 set target traps. `instret` wraps 0xFFFF_FFFF→0.
- `pc_plus4` is purely combinational from `PC`, valid in all states.

## Timing
- Next PC is visible one edge after the cycle in which the decision inputs are sampled. Instruction memory is read combinationally, so instruction latency from `PC` is zero cycles.
- First valid fetch is one cycle after reset release, at RESET_VEC (BOOT cycle).
- Trap entry: 1 edge. Resume from TRAP/HALT: 1 edge, then execution at the held PC.
- Simultaneous `stall`=1 and `halt_req`=1 in RUN: stall wins; halt is taken on the first non-stalled cycle if `halt_req` is still high.

## Test plan
- Reset, release, `pc_src`=00 for 4 cycles → BOOT 1 cycle with `fetch_valid`=0; then `PC` 0x0,0x4,0x8,0xC,0x10, `instret`=4, `pc_plus4`=0x14.
- At `PC`=0x8: `pc_src`=01, `imm`=-8 → `PC`=0x0. `pc_src`=10, `rs1_data`=0x41, `imm`=0x0 → `PC`=0x40 (bit0 cleared).
- At `PC`=0x10: `pc_src`=01, `imm`=0x2 → `trap`=1, `trap_cause`=01, `trap_pc`=0x10, `PC`=0x100, `instret` unchanged. Then `resume` → RUN at 0x100, `trap`=0, cause held at 01.
- `pc_src`=10, target 0x800 (word 512 ≥ MEM_SIZE) → `trap_cause`=10. Misaligned and out-of-range together (0x802) → cause 01.
- `stall`=1 for 3 cycles → PC and `instret` frozen. `halt_req` with `stall`=1 → no halt; after stall drops → PC advances once, HALT, `fetch_valid`=0; `resume` → advancing again.
- Assert `reset` mid-HALT and mid-TRAP, asynchronously between edges → outputs return to reset values immediately; preload `instret`=0xFFFF_FFFF path → wraps to 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter generation and fetch control. Holds the architectural PC,
// selects the next PC (sequential, PC-relative branch/JAL, or JALR), checks
// every target for word alignment and instruction-memory range, and gates
// fetch with a BOOT/RUN/HALT/TRAP state machine. Counts retired instructions.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   stall        freeze PC and all state for this cycle (RUN only)
//   pc_src       next-PC select: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1, 11 as 00
//   imm          sign-extended immediate from decode
//   rs1_data     register-file rs1 read data
//   halt_req     halt after the current instruction retires
//   resume       leave HALT or TRAP
//   PC           current fetch address to instruction memory
//   pc_plus4     PC+4, combinational link value
//   fetch_valid  current PC/instruction is executing
//   trap         high while in TRAP
//   trap_cause   01 misaligned, 10 out of range, 00 none
//   trap_pc      PC of the instruction whose target trapped
//   instret      retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VEC  = '0,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VEC   = ADDR_WIDTH'(32'h0000_0100),
   parameter int                    MEM_SIZE   = 512
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [1:0]            pc_src,
   input  logic [31:0]           imm,
   input  logic [31:0]           rs1_data,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic [ADDR_WIDTH-1:0] pc_plus4,
   output logic                  fetch_valid,
   output logic                  trap,
   output logic [1:0]            trap_cause,
   output logic [ADDR_WIDTH-1:0] trap_pc,
   output logic [31:0]           instret
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_TRAP = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_SIZE);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
   logic [1:0]              trap_cause_reg, trap_cause_next;
   logic [ADDR_WIDTH-1:0]   trap_pc_reg, trap_pc_next;
   logic [31:0]             instret_reg, instret_next;

   logic [ADDR_WIDTH-1:0]   imm_ext;
   logic [ADDR_WIDTH-1:0]   rs1_ext;
   logic [ADDR_WIDTH-1:0]   target;
   logic [ADDR_WIDTH-1:0]   target_word;
   logic                    misaligned;
   logic                    out_of_range;

   assign imm_ext  = ADDR_WIDTH'($signed(imm));
   assign rs1_ext  = ADDR_WIDTH'(rs1_data);
   assign pc_plus4 = pc_reg + ADDR_WIDTH'(4);

   // Target selection; JALR clears bit 0 only, so a set bit 1 still traps.
   always_comb begin
      target = pc_plus4;
      case (pc_src)
         2'b01:   target = pc_reg + imm_ext;
         2'b10:   target = (rs1_ext + imm_ext) & ~ADDR_WIDTH'(1);
         default: target = pc_plus4;
      endcase
   end

   assign target_word  = {2'b00, target[ADDR_WIDTH-1:2]};
   assign misaligned   = (target[1:0] != 2'b00);
   assign out_of_range = (target_word >= MEM_WORDS);

   // State register (async reset aborts any state immediately)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_BOOT;
         pc_reg         <= RESET_VEC;
         trap_cause_reg <= 2'b00;
         trap_pc_reg    <= '0;
         instret_reg    <= 32'd0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         trap_cause_reg <= trap_cause_next;
         trap_pc_reg    <= trap_pc_next;
         instret_reg    <= instret_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      trap_cause_next = trap_cause_reg;
      trap_pc_next    = trap_pc_reg;
      instret_next    = instret_reg;
      case (state_reg)
         S_BOOT: state_next = S_RUN;
         S_RUN: begin
            if (!stall) begin
               // Trap checks take priority over halt_req.
               if (misaligned || out_of_range) begin
                  state_next      = S_TRAP;
                  trap_cause_next = misaligned ? 2'b01 : 2'b10;
                  trap_pc_next    = pc_reg;
                  pc_next         = TRAP_VEC;
               end else begin
                  pc_next      = target;
                  instret_next = instret_reg + 32'd1;
                  if (halt_req)
                     state_next = S_HALT;
               end
            end
         end
         S_HALT: if (resume) state_next = S_RUN;
         S_TRAP: if (resume) state_next = S_RUN;
         default: state_next = S_BOOT;
      endcase
   end

   // Outputs
   always_comb begin
      fetch_valid = (state_reg == S_RUN);
      trap        = (state_reg == S_TRAP);
      PC          = pc_reg;
      trap_cause  = trap_cause_reg;
      trap_pc     = trap_pc_reg;
      instret     = instret_reg;
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed table of per-cycle vectors with hand-computed expectations,
// followed by hand-written asynchronous-reset sequences.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  pc_src;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] instret;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .pc_src      (pc_src),
      .imm         (imm),
      .rs1_data    (rs1_data),
      .halt_req    (halt_req),
      .resume      (resume),
      .PC          (pc),
      .pc_plus4    (pc_plus4),
      .fetch_valid (fetch_valid),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .instret     (instret)
   );

   typedef struct {
      string       name;
      logic        stall;
      logic [1:0]  pc_src;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        halt_req;
      logic        resume;
      logic [31:0] exp_pc;
      logic        exp_fv;
      logic        exp_trap;
      logic [1:0]  exp_cause;
      logic [31:0] exp_trap_pc;
      logic [31:0] exp_instret;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_fv,
                            input logic e_trap, input logic [1:0] e_cause,
                            input logic [31:0] e_tpc, input logic [31:0] e_ir);
      chk({tag, ".pc"},          pc,                  e_pc);
      chk({tag, ".pc_plus4"},    pc_plus4,            e_pc + 32'd4);
      chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
      chk({tag, ".trap"},        {31'd0, trap},        {31'd0, e_trap});
      chk({tag, ".trap_cause"},  {30'd0, trap_cause},  {30'd0, e_cause});
      chk({tag, ".trap_pc"},     trap_pc,             e_tpc);
      chk({tag, ".instret"},     instret,             e_ir);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall    = 1'b0;
      pc_src   = 2'b00;
      imm      = 32'd0;
      rs1_data = 32'd0;
      halt_req = 1'b0;
      resume   = 1'b0;
   endtask

   initial begin
      //           name        stl src  imm            rs1           hlt res  pc           fv trp cause trap_pc      instret
      vecs[0]  = '{"boot",     0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h0,       1, 0, 2'd0, 32'h0,       32'd0};
      vecs[1]  = '{"seq4",     0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h4,       1, 0, 2'd0, 32'h0,       32'd1};
      vecs[2]  = '{"seq8",     0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h8,       1, 0, 2'd0, 32'h0,       32'd2};
      vecs[3]  = '{"seqC",     0, 2'd0, 32'd0,         32'd0,        0,  0,  32'hC,       1, 0, 2'd0, 32'h0,       32'd3};
      vecs[4]  = '{"seq10",    0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h10,      1, 0, 2'd0, 32'h0,       32'd4};
      vecs[5]  = '{"br_back",  0, 2'd1, -32'sd8,       32'd0,        0,  0,  32'h8,       1, 0, 2'd0, 32'h0,       32'd5};
      vecs[6]  = '{"br_to0",   0, 2'd1, -32'sd8,       32'd0,        0,  0,  32'h0,       1, 0, 2'd0, 32'h0,       32'd6};
      vecs[7]  = '{"jalr_b0",  0, 2'd2, 32'd0,         32'h41,       0,  0,  32'h40,      1, 0, 2'd0, 32'h0,       32'd7};
      vecs[8]  = '{"src11",    0, 2'd3, 32'd100,       32'h999,      0,  0,  32'h44,      1, 0, 2'd0, 32'h0,       32'd8};
      vecs[9]  = '{"br_10",    0, 2'd1, -32'sd52,      32'd0,        0,  0,  32'h10,      1, 0, 2'd0, 32'h0,       32'd9};
      vecs[10] = '{"trap_mis", 0, 2'd1, 32'd2,         32'd0,        1,  0,  32'h100,     0, 1, 2'd1, 32'h10,      32'd9};
      vecs[11] = '{"trap_hld", 0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h100,     0, 1, 2'd1, 32'h10,      32'd9};
      vecs[12] = '{"resume1",  0, 2'd0, 32'd0,         32'd0,        0,  1,  32'h100,     1, 0, 2'd1, 32'h10,      32'd9};
      vecs[13] = '{"trap_oor", 0, 2'd2, 32'd0,         32'h800,      0,  0,  32'h100,     0, 1, 2'd2, 32'h100,     32'd9};
      vecs[14] = '{"resume2",  0, 2'd0, 32'd0,         32'd0,        0,  1,  32'h100,     1, 0, 2'd2, 32'h100,     32'd9};
      vecs[15] = '{"trap_both",0, 2'd2, 32'd4,         32'h7FE,      0,  0,  32'h100,     0, 1, 2'd1, 32'h100,     32'd9};
      vecs[16] = '{"resume3",  0, 2'd0, 32'd0,         32'd0,        0,  1,  32'h100,     1, 0, 2'd1, 32'h100,     32'd9};
      vecs[17] = '{"jalr_max", 0, 2'd2, 32'd0,         32'h7FD,      0,  0,  32'h7FC,     1, 0, 2'd1, 32'h100,     32'd10};
      vecs[18] = '{"br_to0b",  0, 2'd1, -32'sd2044,    32'd0,        0,  0,  32'h0,       1, 0, 2'd1, 32'h100,     32'd11};
      vecs[19] = '{"stall1",   1, 2'd0, 32'd0,         32'd0,        0,  0,  32'h0,       1, 0, 2'd1, 32'h100,     32'd11};
      vecs[20] = '{"stall2",   1, 2'd1, 32'd2,         32'd0,        0,  0,  32'h0,       1, 0, 2'd1, 32'h100,     32'd11};
      vecs[21] = '{"stall_hlt",1, 2'd0, 32'd0,         32'd0,        1,  0,  32'h0,       1, 0, 2'd1, 32'h100,     32'd11};
      vecs[22] = '{"halt",     0, 2'd0, 32'd0,         32'd0,        1,  0,  32'h4,       0, 0, 2'd1, 32'h100,     32'd12};
      vecs[23] = '{"halt_hld", 0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h4,       0, 0, 2'd1, 32'h100,     32'd12};
      vecs[24] = '{"halt_hl2", 1, 2'd1, 32'd8,         32'd0,        1,  0,  32'h4,       0, 0, 2'd1, 32'h100,     32'd12};
      vecs[25] = '{"resume4",  0, 2'd0, 32'd0,         32'd0,        0,  1,  32'h4,       1, 0, 2'd1, 32'h100,     32'd12};
      vecs[26] = '{"adv8",     0, 2'd0, 32'd0,         32'd0,        0,  0,  32'h8,       1, 0, 2'd1, 32'h100,     32'd13};
      vecs[27] = '{"run_res",  0, 2'd0, 32'd0,         32'd0,        0,  1,  32'hC,       1, 0, 2'd1, 32'h100,     32'd14};

      idle_inputs();
      reset = 1'b1;
      repeat (2) step();
      #3 reset = 1'b0;
      #1;
      // BOOT cycle: reset values, fetch not yet valid
      check_all("reset", 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'd0);

      for (int i = 0; i < 28; i++) begin
         stall    = vecs[i].stall;
         pc_src   = vecs[i].pc_src;
         imm      = vecs[i].imm;
         rs1_data = vecs[i].rs1;
         halt_req = vecs[i].halt_req;
         resume   = vecs[i].resume;
         step();
         $display("vec %0d %s: pc=0x%08h fv=%0b trap=%0b cause=%0d instret=%0d",
                  i, vecs[i].name, pc, fetch_valid, trap, trap_cause, instret);
         check_all(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_fv, vecs[i].exp_trap,
                   vecs[i].exp_cause, vecs[i].exp_trap_pc, vecs[i].exp_instret);
      end

      // Halt at 0xC -> PC 0x10, then asynchronous reset mid-HALT
      idle_inputs();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      check_all("pre_rst_halt", 32'h10, 1'b0, 1'b0, 2'd1, 32'h100, 32'd15);
      #3 reset = 1'b1;
      #1;
      $display("async reset in HALT: pc=0x%08h fv=%0b instret=%0d", pc, fetch_valid, instret);
      check_all("rst_halt", 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'd0);
      step();
      #2 reset = 1'b0;
      step();  // BOOT -> RUN
      check_all("boot2", 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, 32'd0);

      // Misaligned target by 1 -> TRAP, then asynchronous reset mid-TRAP
      pc_src = 2'b01;
      imm    = 32'd1;
      step();
      idle_inputs();
      check_all("pre_rst_trap", 32'h100, 1'b0, 1'b1, 2'd1, 32'h0, 32'd0);
      #3 reset = 1'b1;
      #1;
      $display("async reset in TRAP: pc=0x%08h trap=%0b cause=%0d", pc, trap, trap_cause);
      check_all("rst_trap", 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'd0);
      step();
      #2 reset = 1'b0;
      step();
      step();
      check_all("post_rst_run", 32'h4, 1'b1, 1'b0, 2'd0, 32'h0, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
